// File: rtl/stream_mux_rr_pkg.sv
// stream_mux_rr_pkg
//   Shared definitions for the round-robin stream multiplexer:
//   - state_e   : packet-lock state encoding (IDLE=0, LOCKED=1)
//   - sel_width : width of a channel index, max(1, clog2(n))
package stream_mux_rr_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Constant function so it can size ports; a single channel still needs 1 bit.
  function automatic int sel_width(input int n);
    int w;
    w = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((64'd1 << i) < 64'(n)) w = int'(i) + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter
//   Combinational channel picker.
//   req         : per-channel request
//   ptr         : round-robin start index (must be < N_CH)
//   mode        : 1 = first request at or after ptr (wrapping), 0 = lowest index
//   grant       : chosen channel index (0 when nothing requested)
//   grant_valid : at least one request present
module rr_arbiter
  import stream_mux_rr_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = sel_width(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             mode,
  output logic [SEL_W-1:0] grant,
  output logic             grant_valid
);

  always_comb begin
    int unsigned idx;
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      // Rotating scan in RR mode, plain ascending scan otherwise.
      if (mode) idx = (int'(ptr) + k) % N_CH;
      else      idx = k;
      if (!grant_valid && req[SEL_W'(idx)]) begin
        grant_valid = 1'b1;
        grant       = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//   N_CH-to-1 packet-aware stream multiplexer with a single output register.
//   A channel that starts a multi-beat packet holds the output until its
//   last beat; arbitration (round-robin or fixed priority) happens only
//   between packets.
//   clk, rst               : clock, synchronous active-high reset
//   in_valid/in_data/in_last/in_ready : per-channel input streams
//                            (channel i data at [i*DATA_W +: DATA_W])
//   out_valid/out_data/out_last/out_ch : registered output beat + source channel
//   out_ready              : downstream accept
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter  int N_CH    = 4,
  parameter  int DATA_W  = 8,
  parameter  int RR_MODE = 1,
  localparam int SEL_W   = sel_width(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_last,
  output logic [N_CH-1:0]          in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   lock_ch_q, lock_ch_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic [SEL_W-1:0]   out_ch_q, out_ch_d;

  logic               load;
  logic               xfer;
  logic [SEL_W-1:0]   arb_grant;
  logic               arb_valid;
  logic [SEL_W-1:0]   g;
  logic               g_valid;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_last;

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .req         (in_valid),
    .ptr         (rr_ptr_q),
    .mode        (RR_MODE != 0),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  always_comb begin
    load = !out_valid_q || out_ready;

    // A locked packet owns the output even if its channel is momentarily idle.
    if (state_q == ST_LOCKED) begin
      g       = lock_ch_q;
      g_valid = in_valid[lock_ch_q];
    end else begin
      g       = arb_grant;
      g_valid = arb_valid;
    end

    xfer     = load && g_valid && !rst;
    sel_data = in_data[g*DATA_W +: DATA_W];
    sel_last = in_last[g];

    in_ready = '0;
    if (xfer) in_ready[g] = 1'b1;

    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;

    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_last_d  = sel_last;
      out_ch_d    = g;
      if (sel_last) begin
        state_d  = ST_IDLE;
        rr_ptr_d = (g == SEL_W'(N_CH - 1)) ? '0 : g + SEL_W'(1);
      end else begin
        state_d   = ST_LOCKED;
        lock_ch_d = g;
      end
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lock_ch_q   <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr
//   Two instances (round-robin and fixed priority) driven by the same
//   stimulus, each checked every cycle against a packet-level model, plus
//   literal expectations for the directed scenarios.
module tb_stream_mux_rr;

  logic        clk;
  logic        rst;
  logic [3:0]  vld;
  logic [31:0] dat;
  logic [3:0]  lst;
  logic        ordy;

  logic [3:0]  ir [2];
  logic        ov [2];
  logic [7:0]  od [2];
  logic        ol [2];
  logic [1:0]  oc [2];

  int checks = 0;
  int errors = 0;
  bit armed  = 0;

  typedef struct {
    bit       ov;
    bit [7:0] od;
    bit       ol;
    int       oc;
    bit       locked;
    int       lch;
    int       ptr;
  } model_t;

  model_t m [2];

  int       qch0 [$];
  int       qch1 [$];
  bit [7:0] qd0  [$];
  bit       st3;

  stream_mux_rr #(.N_CH(4), .DATA_W(8), .RR_MODE(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(vld), .in_data(dat), .in_last(lst),
    .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od[0]), .out_last(ol[0]),
    .out_ch(oc[0]), .out_ready(ordy)
  );

  stream_mux_rr #(.N_CH(4), .DATA_W(8), .RR_MODE(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(vld), .in_data(dat), .in_last(lst),
    .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od[1]), .out_last(ol[1]),
    .out_ch(oc[1]), .out_ready(ordy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare one instance against the model, then advance the model.
  task automatic model_step(input int i);
    int       mode;
    bit       load, gv, xfer;
    int       g, c;
    bit [3:0] exp_ir;
    mode   = (i == 0) ? 1 : 0;
    gv     = 0;
    g      = 0;
    xfer   = 0;
    exp_ir = '0;
    if (!rst) begin
      load = !m[i].ov || ordy;
      if (m[i].locked) begin
        g  = m[i].lch;
        gv = vld[g];
      end else begin
        for (int k = 0; k < 4; k++) begin
          c = mode ? (m[i].ptr + k) % 4 : k;
          if (!gv && vld[c]) begin
            gv = 1;
            g  = c;
          end
        end
      end
      xfer = load && gv;
      if (xfer) exp_ir[g] = 1'b1;
    end
    if (armed) begin
      chk($sformatf("in_ready[%0d]", i),  32'(ir[i]), 32'(exp_ir));
      chk($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(m[i].ov));
      chk($sformatf("out_data[%0d]", i),  32'(od[i]), 32'(m[i].od));
      chk($sformatf("out_last[%0d]", i),  32'(ol[i]), 32'(m[i].ol));
      chk($sformatf("out_ch[%0d]", i),    32'(oc[i]), 32'(m[i].oc));
    end
    if (rst) begin
      m[i] = '{default: 0};
    end else if (xfer) begin
      m[i].ov = 1;
      m[i].od = dat[g*8 +: 8];
      m[i].ol = lst[g];
      m[i].oc = g;
      if (lst[g]) begin
        m[i].locked = 0;
        m[i].ptr    = (g + 1) % 4;
      end else begin
        m[i].locked = 1;
        m[i].lch    = g;
      end
    end else if (!m[i].ov || ordy) begin
      m[i].ov = 0;
    end
  endtask

  // One clock: inputs already driven at the falling edge.
  task automatic cycle();
    #1;
    model_step(0);
    model_step(1);
    if (ov[0] === 1'b1) begin
      qch0.push_back(int'(oc[0]));
      qd0.push_back(od[0]);
    end
    if (ov[1] === 1'b1) qch1.push_back(int'(oc[1]));
    if (ir[1][3] === 1'b1) st3 = 1;
    if (rst) armed = 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ch(input int c, input bit v, input logic [7:0] d, input bit l);
    vld[c]       = v;
    dat[c*8 +: 8] = d;
    lst[c]       = l;
  endtask

  task automatic clear_q();
    qch0.delete();
    qch1.delete();
    qd0.delete();
    st3 = 0;
  endtask

  task automatic do_reset();
    rst  = 1;
    vld  = '0;
    dat  = '0;
    lst  = '0;
    ordy = 1;
    cycle();
    cycle();
    rst = 0;
  endtask

  initial begin
    rst  = 1;
    vld  = '0;
    dat  = '0;
    lst  = '0;
    ordy = 1;
    st3  = 0;

    // Reset state
    do_reset();
    chk("reset_out_valid", 32'(ov[0]), 32'd0);
    chk("reset_out_ch",    32'(oc[0]), 32'd0);
    chk("reset_out_data",  32'(od[0]), 32'd0);

    // All four channels single-beat: rotate 0,1,2,3,0 without gaps
    clear_q();
    for (int c = 0; c < 4; c++) set_ch(c, 1, 8'hC0 + 8'(c), 1);
    #1 chk("rr_first_grant", 32'(ir[0]), 32'h1);
    for (int n = 0; n < 6; n++) cycle();
    chk("rr_count", 32'(qch0.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      int exp_seq [5] = '{0, 1, 2, 3, 0};
      chk($sformatf("rr_seq%0d", k), 32'(qch0[k]), 32'(exp_seq[k]));
    end

    // Fixed priority with channels 1 and 3: channel 3 starves
    do_reset();
    clear_q();
    set_ch(1, 1, 8'h11, 1);
    set_ch(3, 1, 8'h33, 1);
    for (int n = 0; n < 6; n++) cycle();
    chk("fp_count", 32'(qch1.size()), 32'd5);
    for (int k = 0; k < qch1.size(); k++) chk($sformatf("fp_ch%0d", k), 32'(qch1[k]), 32'd1);
    chk("fp_ch3_starved", 32'(st3), 32'd0);

    // Ch2 three-beat packet while ch0 waits
    do_reset();
    clear_q();
    set_ch(2, 1, 8'hA1, 0);
    cycle();
    set_ch(2, 1, 8'hA2, 0);
    set_ch(0, 1, 8'h0F, 1);
    cycle();
    set_ch(2, 1, 8'hA3, 1);
    cycle();
    chk("rr_ptr_after_A3", 32'(dut0.rr_ptr_q), 32'd3);
    set_ch(2, 0, 8'h00, 0);
    cycle();
    set_ch(0, 0, 8'h00, 0);
    cycle();
    chk("pkt_count", 32'(qd0.size()), 32'd4);
    begin
      bit [7:0] exp_d [4] = '{8'hA1, 8'hA2, 8'hA3, 8'h0F};
      int       exp_c [4] = '{2, 2, 2, 0};
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("pkt_data%0d", k), 32'(qd0[k]), 32'(exp_d[k]));
        chk($sformatf("pkt_ch%0d", k),   32'(qch0[k]), 32'(exp_c[k]));
      end
    end

    // Back-pressure: 5 stalled cycles hold everything, then resume
    do_reset();
    set_ch(1, 1, 8'h51, 1);
    cycle();
    set_ch(1, 1, 8'h52, 1);
    ordy = 0;
    for (int n = 0; n < 5; n++) begin
      cycle();
      chk("stall_data",  32'(od[0]), 32'h51);
      chk("stall_ch",    32'(oc[0]), 32'd1);
      chk("stall_ready", 32'(ir[0]), 32'h0);
    end
    ordy = 1;
    cycle();
    chk("resume_data",  32'(od[0]), 32'h52);
    chk("resume_valid", 32'(ov[0]), 32'd1);

    // Locked ch1 with a 2-cycle hole; ch3 must wait for ch1 last
    do_reset();
    set_ch(1, 1, 8'hB1, 0);
    set_ch(3, 1, 8'hD3, 1);
    cycle();
    set_ch(1, 0, 8'h00, 0);
    cycle();
    chk("hole1_ready", 32'(ir[0]), 32'h0);
    cycle();
    chk("hole2_ready", 32'(ir[0]), 32'h0);
    chk("hole2_valid", 32'(ov[0]), 32'd0);
    set_ch(1, 1, 8'hB2, 1);
    cycle();
    chk("lock_last_data", 32'(od[0]), 32'hB2);
    set_ch(1, 0, 8'h00, 0);
    cycle();
    chk("after_lock_ch", 32'(oc[0]), 32'd3);

    // Reset in the middle of a locked packet
    do_reset();
    set_ch(2, 1, 8'hC1, 0);
    cycle();
    rst = 1;
    cycle();
    chk("midrst_valid", 32'(ov[0]), 32'd0);
    chk("midrst_ch",    32'(oc[0]), 32'd0);
    rst = 0;
    set_ch(0, 1, 8'hE0, 1);
    set_ch(2, 1, 8'hC2, 1);
    #1 chk("midrst_grant", 32'(ir[0]), 32'h1);
    cycle();
    chk("midrst_first_ch",   32'(oc[0]), 32'd0);
    chk("midrst_first_data", 32'(od[0]), 32'hE0);
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
